// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
// Single-clock parametrised FIFO with programmable almost-full/almost-empty
// flags, a fill count and sticky overflow/underflow error flags.
//
// Optional feature macro: SYNC_FIFO_FWFT_EN
//   undefined : standard mode. A read is registered: rd_data_o loads on the
//               accepting edge and rd_valid_o pulses for one cycle.
//   defined   : first-word-fall-through. rd_data_o always shows the head
//               entry, rd_valid_o = !empty_o, and rd_en_i pops the head.
//
// Ports:
//   clk_i          : clock, rising edge
//   rst_ni         : asynchronous active-low reset
//   wr_en_i        : write request
//   wr_data_i      : write data [DATA_W]
//   full_o         : no free entry
//   almost_full_o  : count >= AF_LEVEL
//   rd_en_i        : read request / head acknowledge (FWFT)
//   rd_data_o      : read data [DATA_W]
//   rd_valid_o     : rd_data_o is valid
//   empty_o        : no stored entry
//   almost_empty_o : count <= AE_LEVEL
//   count_o        : stored entries [ADDR_W+1]
//   clr_err_i      : synchronous clear of the sticky error flags
//   overflow_o     : sticky, write attempted while full
//   underflow_o    : sticky, read attempted while empty
// ---------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              full_o,
  output logic              almost_full_o,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              empty_o,
  output logic              almost_empty_o,
  output logic [ADDR_W:0]   count_o,
  input  logic              clr_err_i,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_LVL   = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_LVL   = AE_LEVEL[ADDR_W:0];

  logic [DATA_W-1:0] ram_q [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [ADDR_W:0]   count_s;
  logic              full_s, empty_s;
  logic              wr_acc_s, rd_acc_s;

  // Flags decode straight from the registered pointers; the wrap bit
  // separates full (difference = DEPTH) from empty (difference = 0).
  assign count_s  = wr_ptr_q - rd_ptr_q;
  assign full_s   = (count_s == CNT_FULL);
  assign empty_s  = (count_s == {(ADDR_W+1){1'b0}});
  assign wr_acc_s = wr_en_i & ~full_s;
  assign rd_acc_s = rd_en_i & ~empty_s;

  // Next-state for pointers and sticky error flags; a new error wins over clr_err_i.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q & ~clr_err_i;
    underflow_d = underflow_q & ~clr_err_i;
    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      overflow_d = overflow_d | wr_en_i;
    end
    if (rd_acc_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      underflow_d = underflow_d | rd_en_i;
    end
  end

  // Pointer and error flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= {(ADDR_W+1){1'b0}};
      rd_ptr_q    <= {(ADDR_W+1){1'b0}};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; deliberately not reset so it can map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_acc_s) begin
      ram_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry is presented combinationally; it is undefined after reset
  // but rd_valid_o masks it while the FIFO is empty.
  assign rd_data_o  = ram_q[rd_ptr_q[ADDR_W-1:0]];
  assign rd_valid_o = ~empty_s;
`else
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  // Registered read port; rd_data_q holds when no read is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q  <= {DATA_W{1'b0}};
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc_s;
      if (rd_acc_s) begin
        rd_data_q <= ram_q[rd_ptr_q[ADDR_W-1:0]];
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
`endif

  assign count_o        = count_s;
  assign full_o         = full_s;
  assign empty_o        = empty_s;
  assign almost_full_o  = (count_s >= AF_LVL);
  assign almost_empty_o = (count_s <= AE_LVL);
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule
